// File: rtl/moving_average_n.sv
// Moving average over a power-of-two window of signed samples.
// One-cycle latency; running sum plus floor or round-half-up average.
module moving_average_n #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0
) (
  input  logic                                system1000,
  input  logic                                system1000_rstn,
  input  logic                                in_valid,
  input  logic signed [WIDTH-1:0]             in_data,
  input  logic                                clear,
  output logic                                out_valid,
  output logic signed [WIDTH-1:0]             out_data,
  output logic signed [WIDTH+LOG2_DEPTH-1:0]  out_sum,
  output logic                                out_full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;

  localparam logic [LOG2_DEPTH:0] FILL_MAX =
    (LOG2_DEPTH+1)'(DEPTH);

  localparam logic signed [SW:0] HALF =
    (SW+1)'((ROUND != 0) ? (1 << (LOG2_DEPTH-1)) : 0);

  localparam logic signed [SW:0] MAXV =
    $signed({{(LOG2_DEPTH+2){1'b0}}, {(WIDTH-1){1'b1}}});

  localparam logic signed [SW:0] MINV =
    $signed({{(LOG2_DEPTH+2){1'b1}}, {(WIDTH-1){1'b0}}});

  logic signed [WIDTH-1:0] buf_q [DEPTH];
  logic [LOG2_DEPTH-1:0]   wptr_q;
  logic [LOG2_DEPTH:0]     fill_q;
  logic [LOG2_DEPTH:0]     fill_next;
  logic signed [SW-1:0]    sum_q;
  logic signed [SW-1:0]    sum_next;
  logic signed [SW-1:0]    in_ext;
  logic signed [SW-1:0]    old_ext;
  logic signed [SW:0]      biased;
  logic signed [SW:0]      shifted;
  logic signed [WIDTH-1:0] avg_next;

  assign in_ext  = {{LOG2_DEPTH{in_data[WIDTH-1]}}, in_data};
  assign old_ext = {{LOG2_DEPTH{buf_q[wptr_q][WIDTH-1]}},
                    buf_q[wptr_q]};

  // Sum width absorbs DEPTH full-scale samples, so no overflow.
  assign sum_next = sum_q + in_ext - old_ext;

  // One extra bit keeps the rounding bias from wrapping.
  assign biased  = {sum_next[SW-1], sum_next} + HALF;
  assign shifted = biased >>> LOG2_DEPTH;

  always_comb begin
    avg_next = shifted[WIDTH-1:0];
    unique case (1'b1)
      (shifted > MAXV): avg_next = MAXV[WIDTH-1:0];
      (shifted < MINV): avg_next = MINV[WIDTH-1:0];
      default:          avg_next = shifted[WIDTH-1:0];
    endcase
  end

  assign fill_next = (fill_q == FILL_MAX) ?
                     fill_q : fill_q + 1'b1;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
      out_full  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
      out_full  <= 1'b0;
    end else if (in_valid) begin
      buf_q[wptr_q] <= in_data;
      wptr_q    <= wptr_q + 1'b1;
      fill_q    <= fill_next;
      sum_q     <= sum_next;
      out_valid <= 1'b1;
      out_data  <= avg_next;
      out_sum   <= sum_next;
      out_full  <= (fill_next == FILL_MAX);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average_n.sv
// Bench for moving_average_n: floor, rounding and 8-deep variants
// driven in lockstep against a queued reference model.
module tb_moving_average_n;

  typedef struct {
    int a0;
    int a1;
    int s0;
    int a2;
    int s2;
    int f0;
    int f2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] din = '0;

  logic               v0, v1, v2;
  logic signed [7:0]  a0, a1;
  logic signed [9:0]  s0, s1;
  logic               f0, f1, f2;
  logic signed [11:0] a2;
  logic signed [14:0] s2;

  always #5 clk = ~clk;

  moving_average_n #(.WIDTH(8), .LOG2_DEPTH(2), .ROUND(0)) u_flr (
    .system1000(clk), .system1000_rstn(rst_n),
    .in_valid(in_valid), .in_data(din[7:0]), .clear(clear),
    .out_valid(v0), .out_data(a0), .out_sum(s0), .out_full(f0)
  );

  moving_average_n #(.WIDTH(8), .LOG2_DEPTH(2), .ROUND(1)) u_rnd (
    .system1000(clk), .system1000_rstn(rst_n),
    .in_valid(in_valid), .in_data(din[7:0]), .clear(clear),
    .out_valid(v1), .out_data(a1), .out_sum(s1), .out_full(f1)
  );

  moving_average_n #(.WIDTH(12), .LOG2_DEPTH(3), .ROUND(0)) u_wide (
    .system1000(clk), .system1000_rstn(rst_n),
    .in_valid(in_valid), .in_data(din), .clear(clear),
    .out_valid(v2), .out_data(a2), .out_sum(s2), .out_full(f2)
  );

  int   checks;
  int   failures;
  int   w8 [4];
  int   w12 [8];
  int   p8, p12, n8, n12;
  exp_t last;
  exp_t q [$];

  task automatic check_eq(input string tag,
                          input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int sat8(input int x);
    return (x > 127) ? 127 : ((x < -128) ? -128 : x);
  endfunction

  task automatic model_clear();
    foreach (w8[i]) w8[i] = 0;
    foreach (w12[i]) w12[i] = 0;
    p8 = 0; p12 = 0; n8 = 0; n12 = 0;
    last = '{default: 0};
  endtask

  task automatic cmp_all();
    check_eq("avg_flr", a0, last.a0);
    check_eq("sum_flr", s0, last.s0);
    check_eq("full_flr", f0, last.f0);
    check_eq("avg_rnd", a1, last.a1);
    check_eq("sum_rnd", s1, last.s0);
    check_eq("full_rnd", f1, last.f0);
    check_eq("avg_wide", a2, last.a2);
    check_eq("sum_wide", s2, last.s2);
    check_eq("full_wide", f2, last.f2);
  endtask

  task automatic step(input bit v, input bit c, input int d);
    exp_t e;
    bit   ev;
    int   x8, x12, t8, t12;
    in_valid = v;
    clear    = c;
    din      = d[11:0];
    ev       = 1'b0;
    if (c) begin
      model_clear();
    end else if (v) begin
      x8  = int'($signed(din[7:0]));
      x12 = int'($signed(din));
      w8[p8]   = x8;
      p8       = (p8 + 1) % 4;
      w12[p12] = x12;
      p12      = (p12 + 1) % 8;
      if (n8 < 4) n8++;
      if (n12 < 8) n12++;
      t8 = 0;
      t12 = 0;
      foreach (w8[i]) t8 += w8[i];
      foreach (w12[i]) t12 += w12[i];
      e.s0 = t8;
      e.a0 = t8 >>> 2;
      e.a1 = sat8((t8 + 2) >>> 2);
      e.f0 = (n8 == 4) ? 1 : 0;
      e.s2 = t12;
      e.a2 = t12 >>> 3;
      e.f2 = (n12 == 8) ? 1 : 0;
      q.push_back(e);
      ev = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("valid_flr", v0, ev);
    check_eq("valid_rnd", v1, ev);
    check_eq("valid_wide", v2, ev);
    if (ev) begin
      if (q.size() == 0) check_eq("sb_empty", 0, 1);
      else last = q.pop_front();
    end
    cmp_all();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    q.delete();
    check_eq("rst_valid", v0, 0);
    cmp_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [5];
    checks   = 0;
    failures = 0;
    seq = '{4, 8, 12, 16, 20};
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_eq("init_valid", v0, 0);
    cmp_all();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, seq[i]);
      check_eq("fill_full", f0, (i >= 3) ? 1 : 0);
    end
    check_eq("fill_avg", a0, 14);
    check_eq("fill_sum", s0, 56);

    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, -1);
    check_eq("neg1_flr", a0, -1);
    check_eq("neg1_sum", s0, -1);
    check_eq("neg1_rnd", a1, 0);

    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 6);
    check_eq("six_rnd", a1, 2);

    step(1'b0, 1'b1, 0);
    repeat (4) step(1'b1, 1'b0, -128);
    check_eq("min_avg", a0, -128);
    check_eq("min_sum", s0, -512);
    repeat (4) step(1'b1, 1'b0, 127);
    check_eq("max_avg", a0, 127);
    check_eq("max_sum", s0, 508);
    check_eq("max_rnd", a1, 127);

    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 8);
    step(1'b0, 1'b0, 0);
    check_eq("gap_hold1", a0, 2);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 8);
    check_eq("gap_avg2", a0, 4);
    step(1'b0, 1'b0, 0);
    check_eq("gap_hold2", a0, 4);

    step(1'b1, 1'b1, 100);
    check_eq("clr_valid", v0, 0);
    check_eq("clr_sum", s0, 0);
    check_eq("clr_full", f0, 0);
    step(1'b1, 1'b0, 4);
    check_eq("clr_next", a0, 1);

    repeat (3) step(1'b1, 1'b0, 40);
    pulse_reset();
    step(1'b1, 1'b0, 40);
    check_eq("rst_avg", a0, 10);
    check_eq("rst_sum", s0, 40);

    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, int'($urandom_range(0, 4095)));
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 0);
    end

    check_eq("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moving_average_n.md
MOVING_AVERAGE_N -- requirements
Module: moving_average_n

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have WIDTH, 8: sample and result width in bits, signed two's complement, minimum 2.
REQ-002 SHALL have LOG2_DEPTH, 2: window depth is DEPTH = 2^LOG2_DEPTH samples, range 1..8.
REQ-003 SHALL have ROUND, 0: result rounding, 0 = floor (arithmetic shift), 1 = round-half-up.

Ports (name, direction, width, meaning):
REQ-004 SHALL have system1000, in, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have system1000_rstn, in, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have in_valid, in, 1: in_data carries a new sample this cycle.
REQ-007 SHALL have in_data, in, WIDTH: signed input sample.
REQ-008 SHALL have clear, in, 1: synchronous window flush.
REQ-009 SHALL have out_valid, out, 1: out_data and out_sum updated this cycle.
REQ-010 SHALL have out_data, out, WIDTH: signed window average.
REQ-011 SHALL have out_sum, out, WIDTH+LOG2_DEPTH: signed running window sum.
REQ-012 SHALL have out_full, out, 1: DEPTH samples accepted since the last reset or clear.

Function
REQ-013 SHALL keep a circular buffer of DEPTH WIDTH-bit entries, a write pointer (LOG2_DEPTH bits) and a fill counter (saturating at DEPTH).
REQ-014 On in_valid=1 and clear=0: oldest = buf[wptr]; sum <= sum + in_data - oldest; buf[wptr] <= in_data; wptr <= (wptr+1) mod DEPTH; fill counter increments, saturating at DEPTH.
REQ-015 The sum register SHALL be WIDTH+LOG2_DEPTH bits, sign-extending all operands; it never overflows.
REQ-016 ROUND=0: out_data = sum_next >>> LOG2_DEPTH (floor toward minus infinity).
REQ-016a ROUND=1: out_data = (sum_next + 2^(LOG2_DEPTH-1)) >>> LOG2_DEPTH, computed one bit wider, then saturated to the WIDTH range.
REQ-017 Latency SHALL be 1 cycle: out_valid, out_data and out_sum are registered and reflect the sample accepted on the previous edge.
REQ-018 out_data, out_sum and out_full SHALL hold their values when out_valid=0.
REQ-019 Before the window is full, empty slots SHALL count as zero; the divisor stays DEPTH.
REQ-020 out_full SHALL rise registered together with the out_valid of the DEPTH-th accepted sample, and stay high until clear or reset.
REQ-021 Wrap-around: after wptr=DEPTH-1, wptr SHALL return to 0 with no bubble, accepting back-to-back samples every cycle.
REQ-022 clear=1 SHALL zero the buffer, sum, wptr, fill counter, out_data, out_sum and out_full on the next edge, and drive out_valid=0.
REQ-023 clear=1 with in_valid=1 in the same cycle: clear wins and the sample is discarded.
REQ-024 No backpressure: every in_valid=1 sample is accepted.

Reset
REQ-025 While system1000_rstn=0, SHALL asynchronously force buffer, sum, wptr, fill counter, out_valid, out_data, out_sum and out_full to 0.
REQ-026 Reset asserted mid-stream SHALL discard all window history; the first sample after release starts from an empty window.
REQ-027 The first rising edge with system1000_rstn=1 SHALL be a normal operating edge.

Verification (WIDTH=8, LOG2_DEPTH=2 unless stated)
REQ-028 Fill and wrap: samples 4,8,12,16,20 back-to-back -> out_data 1,3,6,10,14; out_sum 4,12,24,40,56; out_full high from the fourth output.
REQ-029 Rounding: single sample -1. ROUND=0 -> out_data=-1, out_sum=-1. ROUND=1 -> out_data=0.
REQ-029a Rounding: single sample 6, ROUND=1 -> out_data=2.
REQ-030 Extremes: four -128 -> out_data=-128, out_sum=-512. Then four 127 -> final out_data=127, out_sum=508, with no overflow.
REQ-031 Gaps and clear: samples 8, 8 with in_valid gaps in between -> outputs 2, 4 only on valid cycles, held otherwise.
REQ-031a Gaps and clear: clear together with in_valid=1 (sample 100) -> next edge out_valid=0, out_sum=0, out_full=0; the next sample 4 -> out_data=1.
REQ-032 Reset mid-operation: rstn low for 2 cycles after three samples of 40 -> all outputs 0 immediately; after release, sample 40 -> out_data=10, out_sum=40.
REQ-033 Parametric: LOG2_DEPTH=3, WIDTH=12, 20 random samples -> out_data and out_sum match a reference model every cycle.
